// File: rtl/gshare_predictor_if.sv
// Fetch/ROB-facing signal bundle of the branch predictor.
// The predictor takes the slave side; the pipeline drives the master side.
interface gshare_predictor_if #(
    parameter int XLEN  = 32,
    parameter int GHR_W = 8
);
    logic             rdy;
    logic             fet_valid;
    logic [XLEN-1:0]  fet_inst_addr;
    logic             bp_pred;
    logic [GHR_W-1:0] bp_ghr;
    logic             bp_ready;
    logic             rob_bp_enable;
    logic [XLEN-1:0]  rob_bp_inst_addr;
    logic [GHR_W-1:0] rob_bp_ghr;
    logic             rob_bp_jump;
    logic             rob_bp_correct;
    logic             rob_clear;
    logic [XLEN-1:0]  bp_correct_cnt;
    logic [XLEN-1:0]  bp_total_cnt;

    modport master (
        output rdy, fet_valid, fet_inst_addr,
        output rob_bp_enable, rob_bp_inst_addr, rob_bp_ghr, rob_bp_jump, rob_bp_correct, rob_clear,
        input  bp_pred, bp_ghr, bp_ready, bp_correct_cnt, bp_total_cnt
    );

    modport slave (
        input  rdy, fet_valid, fet_inst_addr,
        input  rob_bp_enable, rob_bp_inst_addr, rob_bp_ghr, rob_bp_jump, rob_bp_correct, rob_clear,
        output bp_pred, bp_ghr, bp_ready, bp_correct_cnt, bp_total_cnt
    );
endinterface

// File: rtl/gshare_predictor.sv
// Bimodal / gshare branch predictor: PHT of saturating counters, speculative and
// committed global history, init sweep of the table, and saturating accuracy counters.
module gshare_predictor #(
    parameter int XLEN      = 32,
    parameter int PHT_IDX_W = 8,
    parameter int CTR_W     = 2,
    parameter int GHR_W     = 8,
    parameter int MODE      = 1
) (
    input logic                clk,
    input logic                rst,
    gshare_predictor_if.slave  bp
);
    // state   | meaning
    // ST_INIT | sweeping every PHT entry to weakly-not-taken, one per rdy cycle
    // ST_RUN  | predicting and training
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam int                   PHT_ENTRIES = 1 << PHT_IDX_W;
    localparam logic [CTR_W-1:0]     CTR_MAX     = '1;
    localparam logic [CTR_W-1:0]     CTR_INIT    = CTR_MAX >> 1;
    localparam logic [PHT_IDX_W-1:0] LAST_IDX    = '1;
    localparam logic [XLEN-1:0]      CNT_MAX     = '1;

    state_e               state_q, state_d;
    logic [PHT_IDX_W-1:0] sweep_q, sweep_d;
    logic [GHR_W-1:0]     spec_ghr_q, spec_ghr_d;
    logic [GHR_W-1:0]     commit_ghr_q, commit_ghr_d;
    logic [XLEN-1:0]      correct_q, correct_d;
    logic [XLEN-1:0]      total_q, total_d;
    logic [CTR_W-1:0]     pht_q [PHT_ENTRIES];

    logic                 pht_we;
    logic [PHT_IDX_W-1:0] pht_widx;
    logic [CTR_W-1:0]     pht_wdata;
    logic [PHT_IDX_W-1:0] fet_idx, trn_idx;
    logic [CTR_W-1:0]     fet_ctr, trn_ctr;
    logic                 pred;
    logic                 unused_addr_bits;

    function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [XLEN-1:0] addr,
                                                        input logic [GHR_W-1:0] ghr);
        logic [PHT_IDX_W-1:0] base;
        base = addr[PHT_IDX_W:1];
        if (MODE == 1) begin
            return base ^ PHT_IDX_W'(ghr);
        end
        return base;
    endfunction

    // Truncating the concatenation keeps the shift valid for a 1-bit history.
    function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] ghr, input logic bit_in);
        return GHR_W'({ghr, bit_in});
    endfunction

    assign fet_idx = pht_index(bp.fet_inst_addr, spec_ghr_q);
    assign trn_idx = pht_index(bp.rob_bp_inst_addr, bp.rob_bp_ghr);
    assign fet_ctr = pht_q[fet_idx];
    assign trn_ctr = pht_q[trn_idx];
    assign pred    = (state_q == ST_RUN) && fet_ctr[CTR_W-1];

    assign bp.bp_pred        = pred;
    assign bp.bp_ghr         = spec_ghr_q;
    assign bp.bp_ready       = (state_q == ST_RUN);
    assign bp.bp_correct_cnt = correct_q;
    assign bp.bp_total_cnt   = total_q;

    assign unused_addr_bits = ^{bp.fet_inst_addr, bp.rob_bp_inst_addr};

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        spec_ghr_d   = spec_ghr_q;
        commit_ghr_d = commit_ghr_q;
        correct_d    = correct_q;
        total_d      = total_q;
        pht_we       = 1'b0;
        pht_widx     = sweep_q;
        pht_wdata    = CTR_INIT;

        case (state_q)
            ST_INIT: begin
                pht_we  = 1'b1;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (bp.rob_bp_enable) begin
                    pht_we   = 1'b1;
                    pht_widx = trn_idx;
                    if (bp.rob_bp_jump) begin
                        pht_wdata = (trn_ctr == CTR_MAX) ? trn_ctr : trn_ctr + 1'b1;
                    end else begin
                        pht_wdata = (trn_ctr == '0) ? trn_ctr : trn_ctr - 1'b1;
                    end
                    if (total_q != CNT_MAX) begin
                        total_d = total_q + 1'b1;
                    end
                    if (bp.rob_bp_correct && (correct_q != CNT_MAX)) begin
                        correct_d = correct_q + 1'b1;
                    end
                    commit_ghr_d = ghr_shift(commit_ghr_q, bp.rob_bp_jump);
                end
                // Recovery overrides any fetch shift in the same cycle.
                if (bp.rob_clear) begin
                    spec_ghr_d = commit_ghr_d;
                end else if (bp.rob_bp_enable && !bp.rob_bp_correct) begin
                    spec_ghr_d = ghr_shift(bp.rob_bp_ghr, bp.rob_bp_jump);
                end else if (bp.fet_valid) begin
                    spec_ghr_d = ghr_shift(spec_ghr_q, pred);
                end
            end
        endcase

        if (rst) begin
            state_d      = ST_INIT;
            sweep_d      = '0;
            spec_ghr_d   = '0;
            commit_ghr_d = '0;
            correct_d    = '0;
            total_d      = '0;
            pht_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (bp.rdy) begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            spec_ghr_q   <= spec_ghr_d;
            commit_ghr_q <= commit_ghr_d;
            correct_q    <= correct_d;
            total_q      <= total_d;
            if (pht_we) begin
                pht_q[pht_widx] <= pht_wdata;
            end
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench: a gshare instance and a bimodal instance share one stimulus
// stream and are compared against a table/integer reference model.
module tb_gshare_predictor;
    localparam int XLEN = 8;
    localparam int IDXW = 4;
    localparam int NENT = 16;
    localparam int GHRW = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    gshare_predictor_if #(.XLEN(XLEN), .GHR_W(GHRW)) bi ();
    gshare_predictor_if #(.XLEN(XLEN), .GHR_W(GHRW)) bb ();

    gshare_predictor #(.XLEN(XLEN), .PHT_IDX_W(IDXW), .CTR_W(2), .GHR_W(GHRW), .MODE(1))
        dut (.clk(clk), .rst(rst), .bp(bi.slave));
    gshare_predictor #(.XLEN(XLEN), .PHT_IDX_W(IDXW), .CTR_W(2), .GHR_W(GHRW), .MODE(0))
        dut_b (.clk(clk), .rst(rst), .bp(bb.slave));

    assign bb.rdy              = bi.rdy;
    assign bb.fet_valid        = bi.fet_valid;
    assign bb.fet_inst_addr    = bi.fet_inst_addr;
    assign bb.rob_bp_enable    = bi.rob_bp_enable;
    assign bb.rob_bp_inst_addr = bi.rob_bp_inst_addr;
    assign bb.rob_bp_ghr       = bi.rob_bp_ghr;
    assign bb.rob_bp_jump      = bi.rob_bp_jump;
    assign bb.rob_bp_correct   = bi.rob_bp_correct;
    assign bb.rob_clear        = bi.rob_clear;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = bimodal instance, index 1 = gshare instance.
    int m_pht [2][NENT];
    int m_spec [2];
    int m_commit [2];
    int m_ready, m_sweep, m_total, m_correct;

    function automatic int midx(int m, int addr, int ghr);
        return ((addr / 2) % NENT) ^ ((m == 1) ? ghr : 0);
    endfunction

    function automatic int mpred(int m);
        if (m_ready == 0) return 0;
        return (m_pht[m][midx(m, int'(bi.fet_inst_addr), m_spec[m])] >= 2) ? 1 : 0;
    endfunction

    task automatic model_step();
        int ti, nc, p;
        if (!bi.rdy) return;
        if (rst) begin
            m_ready = 0; m_sweep = 0; m_total = 0; m_correct = 0;
            m_spec[0] = 0; m_spec[1] = 0; m_commit[0] = 0; m_commit[1] = 0;
            return;
        end
        if (m_ready == 0) begin
            m_pht[0][m_sweep] = 1;
            m_pht[1][m_sweep] = 1;
            m_sweep++;
            if (m_sweep == NENT) m_ready = 1;
            return;
        end
        for (int m = 0; m < 2; m++) begin
            p  = mpred(m);
            nc = m_commit[m];
            if (bi.rob_bp_enable) begin
                ti = midx(m, int'(bi.rob_bp_inst_addr), int'(bi.rob_bp_ghr));
                if (bi.rob_bp_jump) begin
                    if (m_pht[m][ti] < 3) m_pht[m][ti]++;
                end else begin
                    if (m_pht[m][ti] > 0) m_pht[m][ti]--;
                end
                nc = (m_commit[m] * 2 + int'(bi.rob_bp_jump)) % 16;
            end
            if (bi.rob_clear)
                m_spec[m] = nc;
            else if (bi.rob_bp_enable && !bi.rob_bp_correct)
                m_spec[m] = (int'(bi.rob_bp_ghr) * 2 + int'(bi.rob_bp_jump)) % 16;
            else if (bi.fet_valid)
                m_spec[m] = (m_spec[m] * 2 + p) % 16;
            m_commit[m] = nc;
        end
        if (bi.rob_bp_enable) begin
            if (m_total < 255) m_total++;
            if (bi.rob_bp_correct && m_correct < 255) m_correct++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bi.fet_valid = 0; bi.fet_inst_addr = '0;
        bi.rob_bp_enable = 0; bi.rob_bp_inst_addr = '0; bi.rob_bp_ghr = '0;
        bi.rob_bp_jump = 0; bi.rob_bp_correct = 0; bi.rob_clear = 0;
    endtask

    task automatic commit(input logic [7:0] addr, input logic [3:0] ghr, input logic jump, input logic corr);
        bi.rob_bp_enable = 1; bi.rob_bp_inst_addr = addr; bi.rob_bp_ghr = ghr;
        bi.rob_bp_jump = jump; bi.rob_bp_correct = corr;
        tick();
        bi.rob_bp_enable = 0;
    endtask

    task automatic reset_and_count(output int cnt);
        rst = 1; tick(); rst = 0;
        cnt = 0;
        while (!bi.bp_ready && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        bi.rdy = 1; rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < NENT; i++) begin
            bi.fet_valid = 1; bi.fet_inst_addr = 8'($urandom);
            bi.rob_bp_enable = 1; bi.rob_clear = 1; bi.rob_bp_correct = 1;
            #1;
            checks++;
            if (bi.bp_ready !== 1'b0) begin errors++; $display("FAIL init_ready cyc=%0d got %b want 0", i, bi.bp_ready); end
            checks++;
            if (bi.bp_pred !== 1'b0 || bb.bp_pred !== 1'b0) begin errors++; $display("FAIL init_pred cyc=%0d got %b/%b want 0", i, bi.bp_pred, bb.bp_pred); end
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (bi.bp_ready !== 1'b1 || bb.bp_ready !== 1'b1) begin errors++; $display("FAIL ready_after_16 got %b/%b want 1", bi.bp_ready, bb.bp_ready); end
        checks++;
        if (bi.bp_total_cnt !== 8'd0 || bi.bp_correct_cnt !== 8'd0) begin errors++; $display("FAIL init_counts got %0d/%0d want 0/0", bi.bp_total_cnt, bi.bp_correct_cnt); end
        checks++;
        if (bi.bp_ghr !== 4'd0) begin errors++; $display("FAIL init_ghr got %h want 0", bi.bp_ghr); end
        for (int i = 0; i < NENT; i++) begin
            checks++;
            if (dut.pht_q[i] !== 2'd1 || dut_b.pht_q[i] !== 2'd1) begin
                errors++; $display("FAIL init_entry %0d got %0d/%0d want 1", i, dut.pht_q[i], dut_b.pht_q[i]);
            end
        end
    endtask

    task automatic test_bimodal_train();
        int exp_up [3] = '{2, 3, 3};
        int exp_dn [4] = '{2, 1, 0, 0};
        drive_idle();
        bi.fet_inst_addr = 8'h08;
        #1;
        checks++;
        if (bb.bp_pred !== 1'b0) begin errors++; $display("FAIL bim_pred_pre got %b want 0", bb.bp_pred); end
        for (int i = 0; i < 3; i++) begin
            bi.rob_bp_enable = 1; bi.rob_bp_inst_addr = 8'h08; bi.rob_bp_jump = 1; bi.rob_bp_correct = 1;
            #1;
            checks++;
            if (bb.bp_pred !== logic'(i > 0)) begin errors++; $display("FAIL bim_pred_up %0d got %b want %b", i, bb.bp_pred, i > 0); end
            tick();
            checks++;
            if (dut_b.pht_q[4] !== 2'(exp_up[i])) begin errors++; $display("FAIL bim_ctr_up %0d got %0d want %0d", i, dut_b.pht_q[4], exp_up[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            bi.rob_bp_jump = 0;
            tick();
            checks++;
            if (dut_b.pht_q[4] !== 2'(exp_dn[i])) begin errors++; $display("FAIL bim_ctr_dn %0d got %0d want %0d", i, dut_b.pht_q[4], exp_dn[i]); end
            checks++;
            if (bb.bp_pred !== logic'(exp_dn[i] >= 2)) begin errors++; $display("FAIL bim_pred_dn %0d got %b want %b", i, bb.bp_pred, exp_dn[i] >= 2); end
        end
        drive_idle();
    endtask

    task automatic test_ghr_shift();
        int cnt;
        logic [7:0] addrs [3] = '{8'h10, 8'h02, 8'h20};
        logic [3:0] ghrs [3]  = '{4'b0000, 4'b0001, 4'b0010};
        logic       preds [3] = '{1'b1, 1'b0, 1'b1};
        drive_idle();
        reset_and_count(cnt);
        commit(8'h10, 4'd0, 1, 1); commit(8'h10, 4'd0, 1, 1);
        commit(8'h04, 4'd0, 1, 1); commit(8'h04, 4'd0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            bi.fet_valid = 1; bi.fet_inst_addr = addrs[i];
            #1;
            checks++;
            if (bi.bp_ghr !== ghrs[i] || bi.bp_pred !== preds[i]) begin
                errors++; $display("FAIL ghr_shift %0d got ghr=%b pred=%b want ghr=%b pred=%b", i, bi.bp_ghr, bi.bp_pred, ghrs[i], preds[i]);
            end
            tick();
        end
        bi.fet_valid = 0;
        #1;
        checks++;
        if (bi.bp_ghr !== 4'b0101) begin errors++; $display("FAIL ghr_shift_final got %b want 0101", bi.bp_ghr); end
    endtask

    task automatic test_recover();
        bi.fet_valid = 1; bi.fet_inst_addr = 8'h10;
        commit(8'h00, 4'b0011, 1, 0);
        bi.fet_valid = 0;
        #1;
        checks++;
        if (bi.bp_ghr !== 4'b0111) begin errors++; $display("FAIL recover_ghr got %b want 0111", bi.bp_ghr); end
        checks++;
        if (bi.bp_total_cnt !== 8'd5 || bi.bp_correct_cnt !== 8'd4) begin
            errors++; $display("FAIL recover_counts got %0d/%0d want 5/4", bi.bp_total_cnt, bi.bp_correct_cnt);
        end
    endtask

    task automatic test_clear();
        commit(8'h00, 4'd0, 0, 1); commit(8'h00, 4'd0, 0, 1);
        commit(8'h00, 4'd0, 1, 1); commit(8'h00, 4'd0, 0, 1);
        checks++;
        if (dut.commit_ghr_q !== 4'b0010) begin errors++; $display("FAIL commit_ghr_pre got %b want 0010", dut.commit_ghr_q); end
        bi.rob_clear = 1; bi.fet_valid = 1;
        commit(8'h00, 4'd0, 0, 1);
        drive_idle();
        #1;
        checks++;
        if (dut.commit_ghr_q !== 4'b0100 || bi.bp_ghr !== 4'b0100 || bb.bp_ghr !== 4'b0100) begin
            errors++; $display("FAIL clear_ghr got commit=%b spec=%b/%b want 0100", dut.commit_ghr_q, bi.bp_ghr, bb.bp_ghr);
        end
    endtask

    task automatic test_saturate();
        int c0;
        bi.rob_bp_enable = 1; bi.rob_bp_correct = 0; bi.rob_bp_jump = 1;
        while (m_total < 255) tick();
        drive_idle();
        c0 = m_correct;
        #1;
        checks++;
        if (bi.bp_total_cnt !== 8'hFF || bi.bp_correct_cnt !== 8'(c0)) begin
            errors++; $display("FAIL sat_total got %0d/%0d want 255/%0d", bi.bp_total_cnt, bi.bp_correct_cnt, c0);
        end
        commit(8'h00, 4'd0, 1, 1);
        checks++;
        if (bi.bp_total_cnt !== 8'hFF || bi.bp_correct_cnt !== 8'(c0 + 1)) begin
            errors++; $display("FAIL sat_hold got %0d/%0d want 255/%0d", bi.bp_total_cnt, bi.bp_correct_cnt, c0 + 1);
        end
    endtask

    task automatic test_mid_sweep();
        int cnt;
        drive_idle();
        rst = 1; tick(); rst = 0;
        repeat (9) tick();
        checks++;
        if (dut.sweep_q !== 4'd9) begin errors++; $display("FAIL sweep_ptr got %0d want 9", dut.sweep_q); end
        reset_and_count(cnt);
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL restart_len got %0d want 16", cnt); end
        rst = 1; tick(); rst = 0;
        repeat (5) tick();
        bi.rdy = 0;
        repeat (6) tick();
        rst = 1; tick(); rst = 0;
        checks++;
        if (dut.sweep_q !== 4'd5 || bi.bp_ready !== 1'b0) begin
            errors++; $display("FAIL rdy_freeze got ptr=%0d ready=%b want 5/0", dut.sweep_q, bi.bp_ready);
        end
        bi.rdy = 1;
        cnt = 0;
        while (!bi.bp_ready && cnt < 40) begin tick(); cnt++; end
        checks++;
        if (cnt !== 11) begin errors++; $display("FAIL resume_len got %0d want 11", cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bi.rdy              = ($urandom_range(0, 9) != 0);
            rst                 = ($urandom_range(0, 249) == 0);
            bi.fet_valid        = 1'($urandom);
            bi.fet_inst_addr    = 8'($urandom);
            bi.rob_bp_enable    = 1'($urandom);
            bi.rob_bp_inst_addr = 8'($urandom_range(0, 31));
            bi.rob_bp_ghr       = 4'($urandom);
            bi.rob_bp_jump      = 1'($urandom);
            bi.rob_bp_correct   = ($urandom_range(0, 3) != 0);
            bi.rob_clear        = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (bi.bp_pred !== 1'(mpred(1)) || bb.bp_pred !== 1'(mpred(0))) begin
                errors++; $display("FAIL rnd_pred cyc=%0d got %b/%b want %0d/%0d", i, bi.bp_pred, bb.bp_pred, mpred(1), mpred(0));
            end
            checks++;
            if (bi.bp_ghr !== 4'(m_spec[1]) || bb.bp_ghr !== 4'(m_spec[0])) begin
                errors++; $display("FAIL rnd_ghr cyc=%0d got %h/%h want %h/%h", i, bi.bp_ghr, bb.bp_ghr, m_spec[1], m_spec[0]);
            end
            checks++;
            if (bi.bp_ready !== 1'(m_ready) || bi.bp_total_cnt !== 8'(m_total) || bi.bp_correct_cnt !== 8'(m_correct)) begin
                errors++; $display("FAIL rnd_state cyc=%0d got rdy=%b tot=%0d cor=%0d want %0d/%0d/%0d",
                                   i, bi.bp_ready, bi.bp_total_cnt, bi.bp_correct_cnt, m_ready, m_total, m_correct);
            end
            tick();
        end
        rst = 0; bi.rdy = 1;
        drive_idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_ready = 0; m_sweep = 0; m_total = 0; m_correct = 0;
        m_spec[0] = 0; m_spec[1] = 0; m_commit[0] = 0; m_commit[1] = 0;
        for (int i = 0; i < NENT; i++) begin m_pht[0][i] = 0; m_pht[1][i] = 0; end
        rst = 1;
        bi.rdy = 1;
        drive_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_bimodal_train();
        test_ghr_shift();
        test_recover();
        test_clear();
        test_saturate();
        test_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the per-entry 2-bit bimodal predictor.
- PHT of CTR_W-bit saturating counters, indexed by PC alone (MODE=0) or by PC XOR global history (MODE=1, gshare).
- Keeps a speculative global history register (GHR) plus a committed copy, and recovers the speculative copy on mispredict or ROB clear.
- Clears the PHT with a one-entry-per-cycle init sweep; keeps saturating global accuracy counters. Sits between Fetcher (prediction) and ROB (training).

Parameters:
- XLEN, 32, address/counter width
- PHT_IDX_W, 8, PHT holds 2^PHT_IDX_W entries
- CTR_W, 2, saturating counter width (>=1)
- GHR_W, 8, history length, 1 <= GHR_W <= PHT_IDX_W
- MODE, 1, 0 = bimodal, 1 = gshare

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when 0, all state holds (rst also ignored)
- fet_valid  in  1  Fetcher predicting a conditional branch this cycle
- fet_inst_addr  in  XLEN  branch PC
- bp_pred  out  1  predicted taken (combinational)
- bp_ghr  out  GHR_W  speculative GHR used for this prediction; Fetcher forwards it to ROB
- bp_ready  out  1  init sweep done
- rob_bp_enable  in  1  a branch commits this cycle
- rob_bp_inst_addr  in  XLEN  committing branch PC
- rob_bp_ghr  in  GHR_W  GHR snapshot captured at that branch's prediction
- rob_bp_jump  in  1  actual outcome (1 = taken)
- rob_bp_correct  in  1  prediction was correct
- rob_clear  in  1  pipeline flush for a non-branch cause
- bp_correct_cnt  out  XLEN  saturating count of correct predictions
- bp_total_cnt  out  XLEN  saturating count of committed branches

Behaviour:
- Index:
  - base = addr[PHT_IDX_W:1] (halfword granularity, C extension).
  - MODE=0: idx = base. MODE=1: idx = base XOR zero-extended GHR (GHR in low bits).
  - Fetch index uses spec GHR. Training index uses rob_bp_ghr, never the live GHR.
- Counter init value INIT = 2^(CTR_W-1)-1 (weakly not-taken). bp_pred = counter MSB.
- FSM states INIT, RUN.
  - rst (with rdy): state<=INIT, sweep_ptr<=0, spec_ghr<=0, commit_ghr<=0, both accuracy counts<=0.
  - INIT: PHT[sweep_ptr]<=INIT each rdy cycle, sweep_ptr++. After writing the last entry (ptr = 2^PHT_IDX_W-1), go to RUN. Takes exactly 2^PHT_IDX_W rdy cycles.
  - INIT outputs: bp_ready=0, bp_pred=0. fet_valid, rob_bp_enable and rob_clear are ignored; no counts, no GHR change.
  - rst mid-sweep restarts the sweep from 0.
  - RUN: bp_ready=1.
- Training (RUN, rob_bp_enable):
  - Counter at training idx: +1 if taken and not at max; -1 if not taken and not 0; otherwise hold.
  - total += 1 and correct += rob_bp_correct, each saturating at all-ones (no wrap).
  - commit_ghr <= {commit_ghr[GHR_W-2:0], rob_bp_jump}. For GHR_W=1, the new value is just the outcome.
- spec_ghr next value, priority high to low:
  1. rob_clear: the commit_ghr value after this cycle's update.
  2. rob_bp_enable && !rob_bp_correct: {rob_bp_ghr[GHR_W-2:0], rob_bp_jump}.
  3. fet_valid: {spec_ghr[GHR_W-2:0], bp_pred}.
  4. hold.
  - A fetch shift coinciding with recovery is discarded.
- Fetch and training on the same idx in one cycle: bp_pred shows the pre-update value; the new value is visible next cycle.
- bp_ghr = spec_ghr (current register value, pre-shift).
- Accuracy outputs are registers, not an adder tree over the table.

Test Plan:
1. PHT_IDX_W=4, rst 1 cycle, then rdy=1 -> bp_ready=0 for exactly 16 cycles then 1; every entry = 1 (CTR_W=2); counts 0; bp_pred=0 throughout.
2. MODE=0, addr 0x8 trained taken x3 -> counter 1->2->3->3 (saturates); bp_pred 1 from the cycle after the 1st update. Then 4x not-taken -> 3->2->1->0->0.
3. MODE=1, GHR_W=4, spec_ghr=4'b0000, fet_valid x3 with preds 1,0,1 -> bp_ghr 0000, 0001, 0010, then 0101.
4. spec_ghr=4'b0101, commit with rob_bp_ghr=4'b0011, jump=1, correct=0, fet_valid=1 same cycle -> next spec_ghr=4'b0111 (fetch shift dropped); total+1, correct+0.
5. commit_ghr=4'b0010, rob_clear with a simultaneous commit (jump=0) -> commit_ghr and spec_ghr both = 4'b0100.
6. Force total to 0xFFFFFFFF, commit correct branch -> total stays 0xFFFFFFFF, correct +1. Assert rst mid-sweep at ptr=9 -> sweep restarts at 0, bp_ready rises 16 cycles later. rdy=0 during sweep -> ptr frozen.
